// File: rtl/menu_pkg.sv
// -----------------------------------------------------------------------------
// menu_pkg
// Shared types and constants for the menu screen controller.
//   state_t  : controller states (ST_FADE_OUT only exists when the optional
//              fade feature is compiled in with MENU_SCREEN_CTRL_FADE_EN)
//   action_t : decoded key action
//   KEY_*    : USB HID keycodes that the controller reacts to
//   SCR_*    : screen_sel image codes
// -----------------------------------------------------------------------------
package menu_pkg;

    typedef enum logic [1:0] {
        ST_MENU      = 2'd0,
`ifdef MENU_SCREEN_CTRL_FADE_EN
        ST_FADE_OUT  = 2'd1,
`endif
        ST_PLAY      = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_UP    = 3'd1,
        ACT_DOWN  = 3'd2,
        ACT_ENTER = 3'd3,
        ACT_ESC   = 3'd4
    } action_t;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;

    localparam logic [1:0] SCR_MENU      = 2'd0;
    localparam logic [1:0] SCR_PLAY      = 2'd1;
    localparam logic [1:0] SCR_GAME_OVER = 2'd2;

    localparam logic [3:0] FADE_FULL = 4'd15;

    // Map a keycode to the action it triggers; unknown codes do nothing.
    function automatic action_t decode_key(input logic [7:0] code);
        case (code)
            KEY_W:     return ACT_UP;
            KEY_S:     return ACT_DOWN;
            KEY_ENTER: return ACT_ENTER;
            KEY_ESC:   return ACT_ESC;
            default:   return ACT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/menu_screen_ctrl_if.sv
// -----------------------------------------------------------------------------
// menu_screen_ctrl_if
// Signal bundle between the video/keyboard/game side and menu_screen_ctrl.
//   DrawX, DrawY : current pixel position (frame tick at 0,0)
//   keycode      : USB HID keycode, 0x00 = no key
//   game_over    : one-cycle pulse from game logic
//   screen_sel   : image select (MENU / PLAY / GAME_OVER)
//   cursor_idx   : highlighted menu option
//   player_mode  : option latched at game start
//   game_start   : one-cycle pulse on entry to PLAY
//   fade_level   : palette scale, 15 full brightness .. 0 black
// master drives the inputs of the controller; slave is the controller.
// -----------------------------------------------------------------------------
interface menu_screen_ctrl_if;

    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [7:0] keycode;
    logic       game_over;
    logic [1:0] screen_sel;
    logic [1:0] cursor_idx;
    logic [1:0] player_mode;
    logic       game_start;
    logic [3:0] fade_level;

    modport master (
        output DrawX, DrawY, keycode, game_over,
        input  screen_sel, cursor_idx, player_mode, game_start, fade_level
    );

    modport slave (
        input  DrawX, DrawY, keycode, game_over,
        output screen_sel, cursor_idx, player_mode, game_start, fade_level
    );

endinterface

// File: rtl/key_edge.sv
// -----------------------------------------------------------------------------
// key_edge
// Turns the level-type keycode into single key events and decodes them.
// A held key produces one event; releasing (0x00) produces none.
//   vga_clk   : pixel clock
//   reset_n   : synchronous active-low reset
//   i_keycode : raw USB HID keycode
//   o_action  : decoded action for this cycle, ACT_NONE if no event
// -----------------------------------------------------------------------------
module key_edge
    import menu_pkg::*;
(
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic [7:0] i_keycode,
    output action_t    o_action
);

    logic [7:0] r_prev_key;
    logic       w_event;

    // NOTE: clocked state is always written with non-blocking assignments so
    // every register samples the pre-edge values of its inputs.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_prev_key <= 8'h00;
        end else begin
            r_prev_key <= i_keycode;
        end
    end

    assign w_event  = (i_keycode != 8'h00) && (i_keycode != r_prev_key);
    assign o_action = w_event ? decode_key(i_keycode) : ACT_NONE;

endmodule

// File: rtl/menu_screen_ctrl.sv
// -----------------------------------------------------------------------------
// menu_screen_ctrl
// Title-menu / play / game-over screen sequencer for a VGA game.
// Key events are collected into a single pending action per frame and
// committed on the frame tick (DrawX==0 && DrawY==0), so the visible screen
// and cursor only ever change at the start of a frame.
//   vga_clk : pixel clock, the only clock
//   reset_n : synchronous active-low reset
//   bus     : menu_screen_ctrl_if.slave (pixel position, keycode, game_over in;
//             screen_sel, cursor_idx, player_mode, game_start, fade_level out)
// Parameters: NUM_OPTIONS (2..4 cursor positions), FADE_STEP_FRAMES (1..15).
// Optional feature: define MENU_SCREEN_CTRL_FADE_EN to add a fade-out between
// MENU and PLAY; without it fade_level is fixed at 15.
// -----------------------------------------------------------------------------
module menu_screen_ctrl
    import menu_pkg::*;
#(
    parameter int NUM_OPTIONS      = 2,
    parameter int FADE_STEP_FRAMES = 2
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    menu_screen_ctrl_if.slave bus
);

    localparam logic [1:0] CUR_LAST = 2'(NUM_OPTIONS - 1);

    if (NUM_OPTIONS < 2 || NUM_OPTIONS > 4) begin : g_bad_num_options
        $error("menu_screen_ctrl: NUM_OPTIONS must be in 2..4");
    end
    if (FADE_STEP_FRAMES < 1 || FADE_STEP_FRAMES > 15) begin : g_bad_fade_step
        $error("menu_screen_ctrl: FADE_STEP_FRAMES must be in 1..15");
    end

    state_t     r_state,       w_state_nxt;
    logic [1:0] r_cursor,      w_cursor_nxt;
    logic [1:0] r_mode,        w_mode_nxt;
    logic       r_game_start,  w_game_start_nxt;
    action_t    r_pending,     w_pending_nxt;
    logic       r_go_flag,     w_go_flag_nxt;
    action_t    w_action;
    logic       w_tick;
    logic       w_go_now;
    logic [1:0] w_screen_sel;

`ifdef MENU_SCREEN_CTRL_FADE_EN
    localparam logic [3:0] STEP_LAST = 4'(FADE_STEP_FRAMES - 1);
    logic [3:0] r_fade_level, w_fade_level_nxt;
    logic [3:0] r_fade_cnt,   w_fade_cnt_nxt;
`endif

    key_edge u_key_edge (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .i_keycode (bus.keycode),
        .o_action  (w_action)
    );

    assign w_tick   = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);
    // A game_over pulse on the tick cycle itself counts for that tick.
    assign w_go_now = r_go_flag || (bus.game_over && (r_state == ST_PLAY));

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_state      <= ST_MENU;
            r_cursor     <= 2'd0;
            r_mode       <= 2'd0;
            r_game_start <= 1'b0;
            r_pending    <= ACT_NONE;
            r_go_flag    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cursor     <= w_cursor_nxt;
            r_mode       <= w_mode_nxt;
            r_game_start <= w_game_start_nxt;
            r_pending    <= w_pending_nxt;
            r_go_flag    <= w_go_flag_nxt;
        end
    end

`ifdef MENU_SCREEN_CTRL_FADE_EN
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_fade_level <= FADE_FULL;
            r_fade_cnt   <= 4'd0;
        end else begin
            r_fade_level <= w_fade_level_nxt;
            r_fade_cnt   <= w_fade_cnt_nxt;
        end
    end
`endif

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_cursor_nxt     = r_cursor;
        w_mode_nxt       = r_mode;
        w_game_start_nxt = 1'b0;
        w_go_flag_nxt    = w_go_now;
        w_pending_nxt    = (r_pending == ACT_NONE) ? w_action : r_pending;
`ifdef MENU_SCREEN_CTRL_FADE_EN
        w_fade_level_nxt = r_fade_level;
        w_fade_cnt_nxt   = r_fade_cnt;
`endif

        if (w_tick) begin
            // The tick opens a new frame window: an event in this very cycle
            // becomes the first pending action of the new frame.
            w_pending_nxt = w_action;
            w_go_flag_nxt = 1'b0;

            case (r_state)
                ST_MENU: begin
                    case (r_pending)
                        ACT_UP:    w_cursor_nxt = (r_cursor == 2'd0) ? CUR_LAST : r_cursor - 2'd1;
                        ACT_DOWN:  w_cursor_nxt = (r_cursor == CUR_LAST) ? 2'd0 : r_cursor + 2'd1;
                        ACT_ENTER: begin
                            w_mode_nxt = r_cursor;
`ifdef MENU_SCREEN_CTRL_FADE_EN
                            w_state_nxt    = ST_FADE_OUT;
                            w_fade_cnt_nxt = 4'd0;
`else
                            w_state_nxt      = ST_PLAY;
                            w_game_start_nxt = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
`ifdef MENU_SCREEN_CTRL_FADE_EN
                ST_FADE_OUT: begin
                    // Each level is held for FADE_STEP_FRAMES ticks; level 0
                    // too, after which the game starts at full brightness.
                    if (r_fade_cnt == STEP_LAST) begin
                        w_fade_cnt_nxt = 4'd0;
                        if (r_fade_level == 4'd0) begin
                            w_state_nxt      = ST_PLAY;
                            w_fade_level_nxt = FADE_FULL;
                            w_game_start_nxt = 1'b1;
                        end else begin
                            w_fade_level_nxt = r_fade_level - 4'd1;
                        end
                    end else begin
                        w_fade_cnt_nxt = r_fade_cnt + 4'd1;
                    end
                end
`endif
                ST_PLAY: begin
                    if (w_go_now) begin
                        w_state_nxt = ST_GAME_OVER;
                    end else if (r_pending == ACT_ESC) begin
                        w_state_nxt = ST_MENU;
                    end
                end
                ST_GAME_OVER: begin
                    if (r_pending == ACT_ENTER || r_pending == ACT_ESC) begin
                        w_state_nxt  = ST_MENU;
                        w_cursor_nxt = 2'd0;
                    end
                end
                default: w_state_nxt = ST_MENU;
            endcase
        end
    end

    always_comb begin
        case (r_state)
            ST_PLAY:      w_screen_sel = SCR_PLAY;
            ST_GAME_OVER: w_screen_sel = SCR_GAME_OVER;
            default:      w_screen_sel = SCR_MENU;
        endcase
    end

    assign bus.screen_sel  = w_screen_sel;
    assign bus.cursor_idx  = r_cursor;
    assign bus.player_mode = r_mode;
    assign bus.game_start  = r_game_start;
`ifdef MENU_SCREEN_CTRL_FADE_EN
    assign bus.fade_level  = r_fade_level;
`else
    assign bus.fade_level  = FADE_FULL;
`endif

endmodule
